// File: rtl/axi_sram_slave.sv
// AXI4 SRAM slave: independent read and write burst engines sharing one word array.
// Read data is registered per beat; the write engine merges byte lanes under wstrb.
module axi_sram_slave #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 2,
  parameter logic [ADDR_W-1:0] BASE = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [ID_W-1:0]     awid,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  output logic [ID_W-1:0]     bid,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [ID_W-1:0]     arid,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic [ID_W-1:0]     rid,
  output logic [1:0]          dbg_rd_state,
  output logic [1:0]          dbg_wr_state
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int LANE_LOG2 = $clog2(STRB_W);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return (a >= BASE) && ((off >> (LANE_LOG2 + DEPTH_LOG2)) == '0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return off[LANE_LOG2 +: DEPTH_LOG2];
  endfunction

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    return (burst == 2'b01) ? a + (ADDR_W'(1) << size) : a;
  endfunction

  // Handshakes: a transfer happens on the rising edge where valid and ready are both 1;
  // ready/valid outputs depend only on engine state, never on the peer's valid/ready.

  // ---------------- read engine ----------------
  logic [1:0]        r_state;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_beat;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [ADDR_W-1:0] r_addr_next;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_bad;
  logic              fetch_last;
  logic              fetch_ok;

  assign arready      = rst_n && (r_state == R_IDLE);
  assign rvalid       = (r_state == R_DATA);
  assign dbg_rd_state = r_state;
  assign r_addr_next  = step_addr(r_addr, r_size, r_burst);

  // fetch_* selects which beat gets loaded into the registered R outputs this edge.
  always_comb begin
    fetch_en   = 1'b0;
    fetch_addr = r_addr;
    fetch_bad  = r_burst[1];
    fetch_last = (r_beat == r_len);
    case (r_state)
      R_IDLE: if (arvalid && (RD_LAT == 0)) begin
        fetch_en   = 1'b1;
        fetch_addr = araddr;
        fetch_bad  = arburst[1];
        fetch_last = (arlen == 8'd0);
      end
      R_WAIT: fetch_en = (r_cnt == 8'd1);
      R_DATA: if (rready && !rlast) begin
        fetch_en   = 1'b1;
        fetch_addr = r_addr_next;
        fetch_last = (r_beat + 8'd1 == r_len);
      end
      default: ;
    endcase
  end

  assign fetch_ok = !fetch_bad && in_range(fetch_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= '0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
    end else begin
      if (fetch_en) begin
        rdata <= fetch_ok ? mem[word_idx(fetch_addr)] : '0;
        rresp <= fetch_ok ? 2'b00 : 2'b10;
        rlast <= fetch_last;
      end
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_addr  <= araddr;
          r_len   <= arlen;
          r_size  <= arsize;
          r_burst <= arburst;
          rid     <= arid;
          r_beat  <= '0;
          r_cnt   <= 8'(RD_LAT);
          r_state <= (RD_LAT == 0) ? R_DATA : R_WAIT;
        end
        R_WAIT: begin
          if (r_cnt == 8'd1) r_state <= R_DATA;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        R_DATA: if (rready) begin
          if (rlast) begin
            r_state <= R_IDLE;
          end else begin
            r_addr <= r_addr_next;
            r_beat <= r_beat + 8'd1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write engine ----------------
  logic [1:0]        w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [7:0]        w_beat;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err;
  logic              wr_fire;
  logic              wr_ok;
  logic              wr_last;
  logic              wr_err;

  assign awready      = rst_n && (w_state == W_IDLE);
  assign wready       = (w_state == W_DATA);
  assign bvalid       = (w_state == W_RESP);
  assign dbg_wr_state = w_state;
  assign wr_fire      = rst_n && wvalid && wready;
  assign wr_ok        = !w_burst[1] && in_range(w_addr);
  assign wr_last      = (w_beat == w_len);
  // Burst length is trusted over wlast; a disagreeing wlast only poisons the response.
  assign wr_err       = w_err || !wr_ok || (wlast != wr_last);

  always_ff @(posedge clk) begin
    if (wr_fire && wr_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[word_idx(w_addr)][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          bid     <= awid;
          w_beat  <= '0;
          w_err   <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_err <= wr_err;
          if (wr_last) begin
            bresp   <= wr_err ? 2'b10 : 2'b00;
            w_state <= W_RESP;
          end else begin
            w_addr <= step_addr(w_addr, w_size, w_burst);
            w_beat <= w_beat + 8'd1;
          end
        end
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed scenarios plus random bursts, checked against a
// word-level memory model that applies AXI burst/strobe rules arithmetically.
module tb_axi_sram_slave;

  localparam int DEPTH_LOG2 = 12;
  localparam int RD_LAT     = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  logic [1:0]  dbg_rd_state, dbg_wr_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] ref_mem [int];
  logic [63:0] wr_data [256];
  logic [7:0]  wr_strb [256];

  axi_sram_slave #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4), .DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT), .BASE(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_ok(input logic [31:0] a, input logic [1:0] burst);
    return (burst != 2'b10) && (burst != 2'b11) && (a >= BASE) &&
           ((a - BASE) < (32'd8 << DEPTH_LOG2));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 32'd8);
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a, input int i,
                                         input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b01) return a + 32'(i) * (32'd1 << size);
    return a;
  endfunction

  // ---------------- drivers ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit bad_wlast);
    int bad_beat, guard, hold;
    bit err, last_i;
    logic [31:0] a;
    logic [1:0] exp_resp;
    bad_beat = bad_wlast ? int'($urandom_range(0, int'(len))) : -1;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = m_addr(addr, i, size, burst);
      last_i = (i == int'(len));
      if (m_ok(a, burst)) begin
        for (int b = 0; b < 8; b++)
          if (wr_strb[i][b]) ref_mem[m_idx(a)][b*8 +: 8] = wr_data[i][b*8 +: 8];
      end else begin
        err = 1'b1;
      end
      if (i == bad_beat) err = 1'b1;
    end
    exp_resp = err ? 2'b10 : 2'b00;

    awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 100) begin @(negedge clk); guard++; end
    if (!awready) begin check("aw_timeout", 0, 1); awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wr_data[i]; wstrb = wr_strb[i];
      wlast = (i == int'(len)) ^ (i == bad_beat);
      wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < 100) begin @(negedge clk); guard++; end
      if (!wready) begin check("w_timeout", 0, 1); wvalid = 1'b0; return; end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    guard = 0;
    while (!bvalid && guard < 100) begin @(negedge clk); guard++; end
    if (!bvalid) begin check("b_timeout", 0, 1); return; end
    hold = $urandom_range(0, 2);
    for (int s = 0; s < hold; s++) begin
      check("b_hold_valid", bvalid, 1);
      @(negedge clk);
    end
    check("b_resp", bresp, exp_resp);
    check("b_id", bid, id);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_done", bvalid, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int stall,
                          input bit chk_lat);
    logic [63:0] exp_q[$];
    logic [1:0]  exp_resp_q[$];
    logic [31:0] a;
    int guard, lat, gap, beat;
    for (int i = 0; i <= int'(len); i++) begin
      a = m_addr(addr, i, size, burst);
      exp_q.push_back(m_ok(a, burst) ? ref_mem[m_idx(a)] : 64'd0);
      exp_resp_q.push_back(m_ok(a, burst) ? 2'b00 : 2'b10);
    end
    araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 100) begin @(negedge clk); guard++; end
    if (!arready) begin check("ar_timeout", 0, 1); arvalid = 1'b0; return; end
    @(negedge clk);
    arvalid = 1'b0;
    rready = (stall == 0);
    lat = 1; gap = 0; beat = 0; guard = 0;
    while (beat <= int'(len) && guard < 200) begin
      if (rvalid) begin
        if (beat == 0 && chk_lat) check("r_first_lat", lat, RD_LAT + 1);
        if (beat > 0 && stall == 0) check("r_gap", gap, 0);
        for (int s = 0; s < stall; s++) begin
          check("r_hold_valid", rvalid, 1);
          check("r_hold_last", rlast, beat == int'(len));
          if (!burst[1]) check("r_hold_data", rdata, exp_q[beat]);
          @(negedge clk);
        end
        rready = 1'b1;
        if (!burst[1]) check("r_data", rdata, exp_q[beat]);
        check("r_resp", rresp, exp_resp_q[beat]);
        check("r_last", rlast, beat == int'(len));
        check("r_id", rid, id);
        beat++; gap = 0;
        @(negedge clk);
        rready = (stall == 0);
      end else begin
        @(negedge clk);
        lat++; gap++; guard++;
      end
    end
    rready = 1'b0;
    if (beat <= int'(len)) begin
      check("r_timeout", beat, int'(len) + 1);
    end else begin
      check("r_arready_after", arready, 1);
      check("r_valid_after", rvalid, 0);
    end
  endtask

  task automatic fill(input int n, input bit rnd_strb);
    for (int i = 0; i < n; i++) begin
      wr_data[i] = {$urandom, $urandom};
      wr_strb[i] = rnd_strb ? 8'($urandom_range(0, 255)) : 8'hFF;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) @(negedge clk);
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_wready", wready, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_arready", arready, 1);
    check("rel_awready", awready, 1);

    // W before AW must be refused
    wvalid = 1'b1; wdata = 64'hDEAD; wstrb = 8'hFF; wlast = 1'b1;
    repeat (2) begin @(negedge clk); check("w_early_wready", wready, 0); end
    wvalid = 1'b0; wlast = 1'b0;

    // preload low 128 words so every later read hits known data
    fill(128, 1'b0);
    axi_write(BASE, 8'd127, 3'd3, 2'b01, 4'd1, 1'b0);

    // directed: two-beat INCR write then read back with latency check
    wr_data[0] = 64'h1122334455667788; wr_strb[0] = 8'hFF;
    wr_data[1] = 64'h99AABBCCDDEEFF00; wr_strb[1] = 8'hFF;
    axi_write(BASE, 8'd1, 3'd3, 2'b01, 4'd3, 1'b0);
    axi_read(BASE, 8'd1, 3'd3, 2'b01, 4'd3, 0, 1'b1);

    // byte-strobe merge
    wr_data[0] = '1; wr_strb[0] = 8'hFF;
    axi_write(BASE + 32'd8, 8'd0, 3'd3, 2'b01, 4'd2, 1'b0);
    wr_data[0] = 64'd0; wr_strb[0] = 8'h0F;
    axi_write(BASE + 32'd8, 8'd0, 3'd3, 2'b01, 4'd2, 1'b0);
    axi_read(BASE + 32'd8, 8'd0, 3'd3, 2'b01, 4'd2, 0, 1'b1);

    // back-pressure hold
    axi_read(BASE, 8'd1, 3'd3, 2'b01, 4'd7, 5, 1'b0);

    // error responses
    axi_read(BASE + (32'd8 << DEPTH_LOG2), 8'd0, 3'd3, 2'b01, 4'd4, 0, 1'b1);
    axi_read(BASE, 8'd0, 3'd3, 2'b10, 4'd5, 0, 1'b1);
    axi_read(BASE - 32'd8, 8'd0, 3'd3, 2'b01, 4'd6, 0, 1'b0);
    fill(2, 1'b0);
    axi_write(BASE - 32'd8, 8'd0, 3'd3, 2'b01, 4'd8, 1'b0);
    axi_write(BASE + (32'd8 << DEPTH_LOG2) - 32'd8, 8'd1, 3'd3, 2'b01, 4'd9, 1'b0);
    axi_read(BASE + (32'd8 << DEPTH_LOG2) - 32'd8, 8'd1, 3'd3, 2'b01, 4'd9, 0, 1'b0);
    fill(3, 1'b1);
    axi_write(BASE + 32'h40, 8'd2, 3'd3, 2'b01, 4'd10, 1'b1);
    axi_read(BASE + 32'h40, 8'd2, 3'd3, 2'b01, 4'd10, 0, 1'b0);

    // concurrent read and write issued on the same edge
    fill(4, 1'b1);
    fork
      axi_write(BASE + 32'h100, 8'd3, 3'd3, 2'b01, 4'd11, 1'b0);
      axi_read(BASE, 8'd3, 3'd3, 2'b01, 4'd12, 0, 1'b1);
    join
    axi_read(BASE + 32'h100, 8'd3, 3'd3, 2'b01, 4'd11, 0, 1'b0);

    // randomized bursts inside the preloaded window
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a;
      logic [7:0]  l;
      logic [2:0]  sz;
      logic [1:0]  bu;
      a  = BASE + 32'($urandom_range(0, 100)) * 32'd8;
      l  = 8'($urandom_range(0, 15));
      sz = 3'($urandom_range(2, 3));
      bu = 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        fill(int'(l) + 1, 1'b1);
        axi_write(a, l, sz, bu, 4'($urandom), $urandom_range(0, 4) == 0);
      end else begin
        axi_read(a, l, sz, bu, 4'($urandom), $urandom_range(0, 2), 1'b1);
      end
    end

    // reset in the middle of a read burst; array must survive
    araddr = BASE; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arid = 4'd13; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    begin
      int guard;
      guard = 0;
      while (!rvalid && guard < 50) begin @(negedge clk); guard++; end
    end
    check("mr_beat1_valid", rvalid, 1);
    @(negedge clk);
    check("mr_beat2_valid", rvalid, 1);
    check("mr_beat2_data", rdata, ref_mem[m_idx(BASE) + 1]);
    rready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_rvalid_after_rst", rvalid, 0);
    check("mr_rdata_after_rst", rdata, 0);
    check("mr_rlast_after_rst", rlast, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_arready_rel", arready, 1);
    check("mr_awready_rel", awready, 1);
    axi_read(BASE, 8'd3, 3'd3, 2'b01, 4'd14, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 memory slave directly downstream of the instruction fetch unit's AXI master port.
- Serves instruction fetches on AR/R, and the AW/W/B channels for the load/store unit and testbench preload.
- Backing store is a synchronous-write word array with a configurable read-latency counter.
- Read and write paths are independent state machines sharing one array.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data bus width (8 byte lanes)
ID_W, 4, transaction ID width
DEPTH_LOG2, 12, log2 of number of DATA_W-bit words
RD_LAT, 2, idle cycles between AR handshake and first R beat (0 allowed)
BASE, 32'h8000_0000, byte address of word 0

Ports:
clk input 1 clock
rst_n input 1 synchronous active-low reset
awvalid/awready input/output 1 AW handshake; awaddr in ADDR_W; awid in ID_W; awlen in 8; awsize in 3; awburst in 2
wvalid/wready input/output 1 W handshake; wdata in DATA_W; wstrb in DATA_W/8; wlast in 1
bvalid/bready output/input 1 B handshake; bresp out 2; bid out ID_W
arvalid/arready input/output 1 AR handshake; araddr in ADDR_W; arid in ID_W; arlen in 8; arsize in 3; arburst in 2
rvalid/rready output/input 1 R handshake; rdata out DATA_W; rresp out 2; rlast out 1; rid out ID_W

Behaviour:
- Reset (rst_n low at posedge): all outputs 0, both FSMs to IDLE, in-flight bursts dropped; array contents not cleared. First cycle after release: arready=awready=1.
- Beats per burst = len+1. Address index = (addr-BASE)>>3; full 64-bit word returned, lane selection is the master's job.
- Next-beat address: INCR (2'b01) addr += 1<<size; FIXED (2'b00) unchanged; WRAP (2'b10) and 2'b11 -> every beat SLVERR.
- Out-of-range beat (addr<BASE or index>=2^DEPTH_LOG2): read rdata=0, rresp=2'b10; write discarded, burst bresp=2'b10.
- Read FSM R_IDLE -> R_WAIT -> R_DATA:
  - R_IDLE: arready=1; on arvalid latch addr/id/len/size/burst, load counter=RD_LAT, arready<=0; go R_WAIT (R_DATA if RD_LAT=0).
  - R_WAIT: decrement; at 0 go R_DATA.
  - First rvalid in cycle T+1+RD_LAT, AR handshake at T.
  - R_DATA: rvalid=1, rid=latched id, rlast=(beat==len). rdata/rresp/rlast are registered and stay stable while rready=0.
  - On rvalid&rready: last -> R_IDLE (arready=1 next cycle); else advance address, next beat presented the following cycle, back-to-back allowed.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1; on awvalid latch fields; go W_DATA.
  - W_DATA: wready=1; each wvalid&wready writes bytes where wstrb[i]=1; byte lanes with strobe 0 are unchanged.
  - Burst ends on beat count == len, not on wlast. A wlast value not equal to (beat==len) on any beat sets bresp=SLVERR; the data is still written if in range.
  - W_RESP: bvalid=1, bid=latched id, hold until bready, then W_IDLE.
- Simultaneous read and write to same word in same cycle: read returns old data; write visible from next cycle.
- W data arriving before AW is not accepted: wready=0 outside W_DATA.
- No exclusive access, no 4KB boundary check; arready/awready never 1 while their FSM is busy.

Test Plan:
1. AW addr=BASE, awlen=1, size=3, INCR, id=3; W beats 0x1122334455667788 then 0x99AABBCCDDEEFF00, wstrb=FF -> bresp=00, bid=3. AR same fields -> two R beats with those values, rlast only on beat 2, first rvalid exactly 3 cycles after AR handshake (RD_LAT=2).
2. Word at BASE+8 preset to all-F; write 0x0 with wstrb=0x0F -> read returns 0xFFFFFFFF00000000.
3. 2-beat read with rready low 5 cycles on each beat -> rvalid, rdata and rlast held constant; exactly 2 handshakes; arready=1 the cycle after the last.
4. araddr=BASE+(8<<DEPTH_LOG2), arlen=0 -> one beat, rdata=0, rresp=10, rlast=1. Repeat with arburst=2'b10 at BASE -> rresp=10.
5. Concurrent 4-beat read at BASE and 4-beat write at BASE+0x100, both issued the same cycle -> both complete, R beats back-to-back with rready=1, read data unaffected.
6. rst_n low during 2nd R beat of a 4-beat burst -> rvalid=0 the next cycle. Array data persists: re-read after release returns the pre-reset values.
